mod_updown_counter: RTL and testbench

//   Parametrised modulo up/down counter. Successor to the basic enable counter.
//   - Adds an arbitrary terminal value and direction control.
//   - Adds wrap or saturate mode, parallel load and an enable prescaler.
//   - Adds a terminal-count pulse and a sticky overflow flag.

---
 rtl/counter_pkg.sv | 39 +++
 rtl/counter_prescaler.sv | 33 +++
 rtl/mod_updown_counter.sv | 103 ++++++++++
 tb/tb_mod_updown_counter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and the single-step count function for the modulo up/down counter.
package counter_pkg;

  typedef enum logic {MODE_WRAP, MODE_SAT} mode_e;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  typedef struct packed {
    logic        evt;
    logic [31:0] nxt;
  } step_res_t;

  // Next count for one step; evt flags a boundary (wrap or saturated hold).
  // cnt is always <= max, so +1/-1 never leaves the 0..max range.
  function automatic step_res_t next_count(input logic [31:0] cnt,
                                           input dir_e        dir,
                                           input logic [31:0] max,
                                           input mode_e       mode);
    step_res_t r;
    r.evt = 1'b0;
    r.nxt = cnt;
    if (dir == DIR_UP) begin
      if (cnt >= max) begin
        r.evt = 1'b1;
        r.nxt = (mode == MODE_SAT) ? max : 32'd0;
      end else begin
        r.nxt = cnt + 32'd1;
      end
    end else begin
      if (cnt == 32'd0) begin
        r.evt = 1'b1;
        r.nxt = (mode == MODE_SAT) ? 32'd0 : max;
      end else begin
        r.nxt = cnt - 32'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: asserts step on every PRESCALE-th enabled cycle.
module counter_prescaler #(
  parameter int unsigned PRESCALE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q, phase_d;

  // Phase holds while en is low; clr (load) restarts the count of enabled cycles.
  always_comb begin
    phase_d = phase_q;
    step    = en && (phase_q == LAST);
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = step ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with wrap/saturate mode, parallel load, prescaled
// enable, terminal-count pulse and sticky overflow flag.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter mode_e           MODE     = MODE_WRAP,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "mod_updown_counter: WIDTH must be 1..32");
  end
  if (MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $fatal(1, "mod_updown_counter: MAX_VAL must be 1..2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $fatal(1, "mod_updown_counter: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step_c;
  logic             evt_c;
  logic [WIDTH-1:0] load_clamp_c;
  step_res_t        nc_c;
  logic             unused_c;

  if (PRESCALE > 1) begin : g_pre
    counter_prescaler #(.PRESCALE(PRESCALE)) u_pre (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .clr  (load),
      .step (step_c)
    );
  end else begin : g_nopre
    assign step_c = en;
  end

  // Load beats step; ovf_clr loses to a same-edge boundary event.
  always_comb begin
    count_d      = count_q;
    tc_d         = 1'b0;
    ovf_d        = ovf_q & ~ovf_clr;
    nc_c         = next_count(32'(count_q), dir_e'(up), 32'(MAX_VAL), MODE);
    unused_c     = ^nc_c.nxt;
    load_clamp_c = (load_val > MAX_W) ? MAX_W : load_val;
    evt_c        = 1'b0;
    if (load) begin
      count_d = load_clamp_c;
    end else if (step_c) begin
      count_d = nc_c.nxt[WIDTH-1:0];
      evt_c   = nc_c.evt;
      tc_d    = nc_c.evt;
      ovf_d   = nc_c.evt | (ovf_q & ~ovf_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

  a_count_range : assert property (@(posedge clk) disable iff (reset)
    count_q <= MAX_W);

  a_tc_pulse : assert property (@(posedge clk) disable iff (reset)
    (tc_q && $past(tc_q)) |-> ($past(evt_c) && $past(evt_c, 2)));

  a_load : assert property (@(posedge clk) disable iff (reset)
    load |=> (count_q == $past(load_clamp_c)));

  a_ovf_fall : assert property (@(posedge clk) disable iff (reset)
    $fell(ovf_q) |-> ($past(reset) || ($past(ovf_clr) && !$past(evt_c))));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Drives WRAP, SAT and prescale-3 counters (WIDTH=4, MAX_VAL=9) in lockstep
// and checks them against an arithmetic reference model.
module tb_mod_updown_counter;
  import counter_pkg::*;

  localparam int MAXV = 9;
  localparam int PRE [3] = '{1, 1, 3};
  localparam bit SAT [3] = '{1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       reset, en, up, load, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] cnt_o [3];
  logic       tc_o  [3];
  logic       ovf_o [3];

  int errors = 0;
  int checks = 0;
  int m_cnt [3];
  int m_ph  [3];
  bit m_tc  [3];
  bit m_ovf [3];

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_WRAP), .PRESCALE(1)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_SAT), .PRESCALE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_WRAP), .PRESCALE(3)) u_pre (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .count(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

  // Reference: counts are plain integers, wrap uses modulo (MAXV+1).
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit stepping, evt;
      if (reset) begin
        m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
        m_ph[i]  = 0;
        m_tc[i]  = 0;
        m_ovf[i] = m_ovf[i] && !ovf_clr;
      end else begin
        stepping = en && (m_ph[i] == PRE[i] - 1);
        if (en) m_ph[i] = stepping ? 0 : m_ph[i] + 1;
        evt = stepping && (up ? (m_cnt[i] == MAXV) : (m_cnt[i] == 0));
        if (stepping) begin
          if (SAT[i]) m_cnt[i] = up ? ((m_cnt[i] + 1 > MAXV) ? MAXV : m_cnt[i] + 1)
                                    : ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1);
          else        m_cnt[i] = up ? (m_cnt[i] + 1) % (MAXV + 1)
                                    : (m_cnt[i] + MAXV) % (MAXV + 1);
        end
        m_tc[i]  = evt;
        m_ovf[i] = evt || (m_ovf[i] && !ovf_clr);
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      checks++;
      assert (cnt_o[i] === 4'(m_cnt[i])) else begin
        errors++;
        $error("FAIL %s dut%0d count got=%0d exp=%0d", tag, i, cnt_o[i], m_cnt[i]);
      end
      checks++;
      assert (tc_o[i] === m_tc[i]) else begin
        errors++;
        $error("FAIL %s dut%0d tc got=%b exp=%b", tag, i, tc_o[i], m_tc[i]);
      end
      checks++;
      assert (ovf_o[i] === m_ovf[i]) else begin
        errors++;
        $error("FAIL %s dut%0d ovf got=%b exp=%b", tag, i, ovf_o[i], m_ovf[i]);
      end
    end
  endtask

  task automatic check_const(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit r, input bit e, input bit u, input bit l,
                       input logic [3:0] lv, input bit oc);
    reset = r; en = e; up = u; load = l; load_val = lv; ovf_clr = oc;
  endtask

  initial begin
    drive(1, 0, 0, 0, 4'd0, 0);
    cyc("reset");

    // Free-running up count through the 9->0 wrap
    drive(0, 1, 1, 0, 4'd0, 0);
    for (int k = 0; k < 12; k++) cyc("count_up");
    check_const("wrap_final_count", cnt_o[0], 4'd2);
    check_const("wrap_final_ovf", {3'b0, ovf_o[0]}, 4'd1);

    // Saturating hold at the top, then count down
    drive(0, 0, 1, 1, 4'd8, 0);
    cyc("load8");
    drive(0, 1, 1, 0, 4'd0, 0);
    for (int k = 0; k < 4; k++) cyc("sat_hold");
    check_const("sat_held", cnt_o[1], 4'd9);
    drive(0, 1, 0, 0, 4'd0, 0);
    for (int k = 0; k < 3; k++) cyc("sat_down");

    // Clamped load, then down-wrap from 0
    drive(0, 0, 0, 1, 4'd15, 0);
    cyc("load15_clamp");
    check_const("clamp", cnt_o[0], 4'd9);
    drive(0, 0, 0, 1, 4'd0, 0);
    cyc("load0");
    drive(0, 1, 0, 0, 4'd0, 0);
    cyc("down_wrap");
    cyc("down_after_wrap");

    // Prescaler: continuous, load mid-phase, then en gaps
    drive(0, 0, 1, 1, 4'd0, 0);
    cyc("pre_load0");
    drive(0, 1, 1, 0, 4'd0, 0);
    for (int k = 0; k < 7; k++) cyc("pre_run");
    drive(0, 1, 1, 1, 4'd4, 0);
    cyc("pre_load_mid");
    drive(0, 1, 1, 0, 4'd0, 0);
    for (int k = 0; k < 4; k++) cyc("pre_after_load");
    for (int k = 0; k < 8; k++) begin
      en = k[0];
      cyc("pre_gaps");
    end

    // ovf_clr on the wrap edge loses; ovf_clr alone clears
    drive(0, 0, 1, 1, 4'd9, 0);
    cyc("load9");
    drive(0, 1, 1, 0, 4'd0, 1);
    cyc("clr_on_wrap");
    drive(0, 0, 1, 0, 4'd0, 1);
    cyc("clr_no_event");
    drive(0, 0, 1, 0, 4'd0, 0);
    cyc("idle");

    // Reset beats load and wrap; load beats step
    drive(0, 0, 1, 1, 4'd9, 0);
    cyc("load9b");
    drive(1, 1, 1, 1, 4'd5, 0);
    cyc("reset_over_load");
    drive(0, 1, 1, 1, 4'd9, 0);
    cyc("load_over_step");
    drive(0, 0, 1, 1, 4'd9, 0);
    cyc("load_again");
    drive(0, 1, 1, 1, 4'd3, 0);
    cyc("load_at_top_with_en");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom), ($urandom_range(0, 9) == 0),
            4'($urandom), ($urandom_range(0, 7) == 0));
      cyc("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
